// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches, buffers PC-tagged responses in order,
// and flushes on redirect while discarding responses still in flight.
module fetch_queue #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SW = ((CW > OW) ? CW : OW) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic [SW-1:0] reserved;
    logic          req_fire;
    logic          rsp_take;
    logic          push;
    logic          pop;

    // Entries already buffered plus responses that will still land in the FIFO.
    assign reserved = SW'(count) + SW'(outstanding) - SW'(drop_cnt);

    assign imem_req_valid = !rst && !redirect_valid
                          && (outstanding < OW'(MAX_OUTSTANDING))
                          && (reserved < SW'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_take       = imem_rsp_valid && (outstanding != '0);
    assign push           = rsp_take && (drop_cnt == '0) && !redirect_valid && !rst;

    assign out_valid = !rst && (count != '0);
    assign out_pc    = out_valid ? pc_mem[rd_ptr]    : 32'h0;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : 32'h0;
    assign pop       = out_valid && out_ready && !redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old stream.
            fetch_pc    <= redirect_pc & 32'hFFFF_FFFC;
            rsp_pc      <= redirect_pc & 32'hFFFF_FFFC;
            outstanding <= outstanding - OW'(rsp_take);
            drop_cnt    <= outstanding - OW'(rsp_take);
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + OW'(req_fire) - OW'(rsp_take);
            if (rsp_take && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - OW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                rsp_pc <= rsp_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Payload storage needs no reset; reads are masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= rsp_pc;
            instr_mem[wr_ptr] <= imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model plus an in-order memory model.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam int          MAXO     = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;

    fetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int mem_lat  = 1;

    // Memory side: accepted requests waiting to be answered, in order.
    logic [31:0] mq_addr [$];
    int          mq_due  [$];

    // Reference model: in-flight requests (with stale flag), FIFO of PCs, next fetch PC.
    logic [31:0] m_if_addr  [$];
    bit          m_if_stale [$];
    logic [31:0] m_fifo     [$];
    logic [31:0] m_pc;

    function automatic logic [31:0] img(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F ^ {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input bit r, input bit redir, input logic [31:0] rpc,
                        input bit ordy, input bit qrdy);
        bit          exp_req;
        bit          exp_ov;
        bit          st;
        int          live;
        logic [31:0] a;
        @(negedge clk);
        rst            = r;
        redirect_valid = redir;
        redirect_pc    = rpc;
        out_ready      = ordy;
        imem_req_ready = qrdy;
        if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = img(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        live = 0;
        foreach (m_if_stale[i]) if (!m_if_stale[i]) live++;
        exp_req = !r && !redir && (m_if_addr.size() < MAXO) && (m_fifo.size() + live < DEPTH);
        exp_ov  = !r && (m_fifo.size() != 0);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
        if (exp_req) chk("req_addr", imem_req_addr, m_pc);
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            chk("out_pc", out_pc, m_fifo[0]);
            chk("out_instr", out_instr, img(m_fifo[0]));
        end else begin
            chk("out_pc_empty", out_pc, 32'h0);
            chk("out_instr_empty", out_instr, 32'h0);
        end
        // Memory accepts whatever the DUT actually hands over.
        if (imem_req_valid && qrdy) begin
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(cyc + ((mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat));
        end
        // Advance the reference model by one clock.
        if (r) begin
            m_if_addr.delete();
            m_if_stale.delete();
            m_fifo.delete();
            m_pc = RESET_PC;
        end else if (redir) begin
            if (imem_rsp_valid && m_if_addr.size() != 0) begin
                void'(m_if_addr.pop_front());
                void'(m_if_stale.pop_front());
            end
            foreach (m_if_stale[i]) m_if_stale[i] = 1'b1;
            m_fifo.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
        end else begin
            if (exp_ov && ordy) void'(m_fifo.pop_front());
            if (imem_rsp_valid && m_if_addr.size() != 0) begin
                a  = m_if_addr.pop_front();
                st = m_if_stale.pop_front();
                if (!st) m_fifo.push_back(a);
            end
            if (exp_req && qrdy) begin
                m_if_addr.push_back(m_pc);
                m_if_stale.push_back(1'b0);
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    initial begin
        bit          reached;
        logic [31:0] rpc;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        m_pc = RESET_PC;

        repeat (3) step(1, 0, 0, 0, 0);

        // Zero-wait memory, core always ready: one instruction per cycle.
        mem_lat = 1;
        repeat (30) step(0, 0, 0, 1, 1);

        // Core stalled: FIFO fills to DEPTH, then drains in order.
        repeat (20) step(0, 0, 0, 0, 1);
        repeat (15) step(0, 0, 0, 1, 1);

        // Slow memory, redirect with two requests in flight.
        mem_lat = 3;
        reached = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_if_addr.size() == MAXO) begin reached = 1; break; end
            step(0, 0, 0, 1, 1);
        end
        chk("reach_two_inflight", 32'(reached), 32'd1);
        step(0, 1, 32'h0000_0100, 1, 1);
        repeat (25) step(0, 0, 0, 1, 1);

        // Redirect coinciding with a response and a pop.
        mem_lat = 1;
        reached = 0;
        for (int i = 0; i < 20; i++) begin
            if (mq_addr.size() != 0 && mq_due[0] <= cyc && m_fifo.size() != 0) begin
                reached = 1; break;
            end
            step(0, 0, 0, 1, 1);
        end
        chk("reach_rsp_pop", 32'(reached), 32'd1);
        step(0, 1, 32'h0000_0203, 1, 1);
        repeat (10) step(0, 0, 0, 1, 1);

        // Random handshakes, latencies and redirects, including near the address wrap.
        mem_lat = 0;
        for (int i = 0; i < 1000; i++) begin
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            step(0, $urandom_range(0, 39) == 0, rpc,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end

        // Reset with requests in flight and entries buffered.
        mem_lat = 4;
        repeat (10) step(0, 0, 0, 1, 0);
        reached = 0;
        for (int i = 0; i < 40; i++) begin
            if (m_fifo.size() >= 2 && m_if_addr.size() == MAXO) begin reached = 1; break; end
            step(0, 0, 0, 0, 1);
        end
        chk("reach_busy_before_reset", 32'(reached), 32'd1);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 10 && mq_addr.size() != 0; i++) step(0, 0, 0, 1, 0);
        chk("late_rsp_drained", 32'(mq_addr.size()), 32'd0);
        mem_lat = 1;
        repeat (20) step(0, 0, 0, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
